cache_wr_ctrl: RTL and testbench

CACHE_WR_CTRL -- requirements
Module: cache_wr_ctrl

---
 rtl/cache_wr_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cache_wr_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_wr_ctrl.sv
// Packet write controller: allocates cache IDs from a 63-entry free pool.
// Optional drop counter built only when CACHE_DROP_CNT_EN is defined.
module cache_wr_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [133:0] in_cache_data,
    input  logic         in_cache_data_wr,
    input  logic         in_cache_valid,
    input  logic         in_cache_valid_wr,
    input  logic [5:0]   in_release_ID,
    input  logic         in_release_wr,
    output logic [7:0]   out_cache_ID,
    output logic [5:0]   out_cache_ID_count,
    output logic [12:0]  out_ram_addr,
    output logic [133:0] out_ram_data,
    output logic         out_ram_wr,
    output logic [5:0]   out_commit_ID,
    output logic [7:0]   out_commit_len,
    output logic         out_commit_wr,
    output logic         out_cache_err,
    output logic [15:0]  out_cache_drop_count
);

    typedef enum logic [1:0] {
        IDLE_S,
        WR_S,
        DROP_S
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] free, free_nxt;
    logic [5:0]  count;
    logic [5:0]  cur_id, id_nxt, alloc_id, wr_id;
    logic [7:0]  idx, idx_nxt;
    logic [6:0]  wr_idx;
    logic        oversize, over_nxt, over;
    logic        alloc_en, rel_int, wr_en, commit_en;
    logic        is_head, is_tail, good;
    logic        ext_ok, ext_err;
`ifdef CACHE_DROP_CNT_EN
    logic        drop_inc;
    logic [15:0] drop_cnt;
`endif

    assign is_head = in_cache_data_wr && (in_cache_data[133:132] == 2'b01);
    assign is_tail = in_cache_data_wr && (in_cache_data[133:132] == 2'b10);
    assign ext_ok  = in_release_wr && (in_release_ID != 6'd0)
                     && !free[in_release_ID];
    assign ext_err = in_release_wr && !ext_ok;
    assign good    = in_cache_valid_wr && in_cache_valid && !over;

    always_comb begin
        alloc_id = '0;
        for (int i = 63; i >= 1; i--)
            if (free[i]) alloc_id = 6'(i);
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        over_nxt  = oversize;
        id_nxt    = cur_id;
        alloc_en  = 1'b0;
        rel_int   = 1'b0;
        wr_en     = 1'b0;
        wr_id     = cur_id;
        wr_idx    = idx[6:0];
        commit_en = 1'b0;
        over      = oversize || idx[7];
`ifdef CACHE_DROP_CNT_EN
        drop_inc  = 1'b0;
`endif
        if (is_head) begin
            // a head always restarts; an open packet gives its ID back
            rel_int = (state == WR_S);
            if (count != 6'd0) begin
                alloc_en  = 1'b1;
                id_nxt    = alloc_id;
                wr_en     = 1'b1;
                wr_id     = alloc_id;
                wr_idx    = '0;
                idx_nxt   = 8'd1;
                over_nxt  = 1'b0;
                state_nxt = WR_S;
            end else begin
`ifdef CACHE_DROP_CNT_EN
                drop_inc  = 1'b1;
`endif
                state_nxt = DROP_S;
            end
        end else if (in_cache_data_wr) begin
            unique case (state)
                IDLE_S: ;
                WR_S: begin
                    if (!idx[7]) begin
                        wr_en   = 1'b1;
                        idx_nxt = idx + 8'd1;
                    end
                    over_nxt = over;
                    if (is_tail) begin
                        state_nxt = IDLE_S;
                        idx_nxt   = '0;
                        over_nxt  = 1'b0;
                        if (good) commit_en = 1'b1;
                        else      rel_int   = 1'b1;
                    end
                end
                DROP_S: if (is_tail) state_nxt = IDLE_S;
                default: state_nxt = IDLE_S;
            endcase
        end
    end

    // alloc, internal and external release never touch the same bit
    always_comb begin
        free_nxt = free;
        if (alloc_en) free_nxt[alloc_id] = 1'b0;
        if (rel_int)  free_nxt[cur_id] = 1'b1;
        if (ext_ok)   free_nxt[in_release_ID] = 1'b1;
        free_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE_S;
            free     <= {{63{1'b1}}, 1'b0};
            count    <= 6'd63;
            cur_id   <= '0;
            idx      <= '0;
            oversize <= 1'b0;
        end else begin
            state    <= state_nxt;
            free     <= free_nxt;
            count    <= 6'($countones(free_nxt));
            cur_id   <= id_nxt;
            idx      <= idx_nxt;
            oversize <= over_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cache_ID   <= '0;
            out_ram_addr   <= '0;
            out_ram_data   <= '0;
            out_ram_wr     <= 1'b0;
            out_commit_ID  <= '0;
            out_commit_len <= '0;
            out_commit_wr  <= 1'b0;
            out_cache_err  <= 1'b0;
        end else begin
            out_ram_wr    <= wr_en;
            out_commit_wr <= commit_en;
            if (alloc_en) out_cache_ID <= {2'b00, alloc_id};
            if (wr_en) begin
                out_ram_addr <= {wr_id, wr_idx};
                out_ram_data <= in_cache_data;
            end
            if (commit_en) begin
                out_commit_ID  <= cur_id;
                out_commit_len <= idx + 8'd1;
            end
            if (ext_err) out_cache_err <= 1'b1;
        end
    end

    assign out_cache_ID_count = count;

`ifdef CACHE_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (drop_inc && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
    assign out_cache_drop_count = drop_cnt;
`else
    assign out_cache_drop_count = '0;
`endif

endmodule

// File: tb/tb_cache_wr_ctrl.sv
// Bench for cache_wr_ctrl: packet-level model plus directed scenarios.
module tb_cache_wr_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [133:0] data = '0;
    logic         data_wr = 1'b0;
    logic         valid = 1'b0;
    logic         valid_wr = 1'b0;
    logic [5:0]   rel_id = '0;
    logic         rel_wr = 1'b0;
    logic [7:0]   cache_id;
    logic [5:0]   id_count;
    logic [12:0]  ram_addr;
    logic [133:0] ram_data;
    logic         ram_wr;
    logic [5:0]   commit_id;
    logic [7:0]   commit_len;
    logic         commit_wr;
    logic         cache_err;
    logic [15:0]  drop_count;

    cache_wr_ctrl dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_cache_data        (data),
        .in_cache_data_wr     (data_wr),
        .in_cache_valid       (valid),
        .in_cache_valid_wr    (valid_wr),
        .in_release_ID        (rel_id),
        .in_release_wr        (rel_wr),
        .out_cache_ID         (cache_id),
        .out_cache_ID_count   (id_count),
        .out_ram_addr         (ram_addr),
        .out_ram_data         (ram_data),
        .out_ram_wr           (ram_wr),
        .out_commit_ID        (commit_id),
        .out_commit_len       (commit_len),
        .out_commit_wr        (commit_wr),
        .out_cache_err        (cache_err),
        .out_cache_drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [133:0] act,
                       input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // packet-level model: free set, open packet, word count
    bit           mfree[64];
    bit           m_act, m_drop, m_over;
    int           m_id, m_words, lowest, nfree, typ;
    int           frees[$];
    logic         e_ram_wr, e_cwr, e_err;
    logic [12:0]  e_addr;
    logic [133:0] e_data;
    logic [5:0]   e_cid, e_cnt;
    logic [7:0]   e_clen, e_id;
    logic [15:0]  e_drops;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mfree[i]) mfree[i] = (i != 0);
            m_act = 0; m_drop = 0; m_over = 0; m_id = 0; m_words = 0;
            e_ram_wr = 0; e_cwr = 0; e_err = 0; e_addr = 0; e_data = 0;
            e_cid = 0; e_clen = 0; e_id = 0; e_cnt = 6'd63; e_drops = 0;
        end else begin
            frees.delete();
            e_ram_wr = 0;
            e_cwr = 0;
            if (rel_wr) begin
                if (rel_id != 0 && !mfree[rel_id]) frees.push_back(int'(rel_id));
                else e_err = 1;
            end
            if (data_wr) begin
                typ = int'(data[133:132]);
                if (typ == 1) begin
                    if (m_act) frees.push_back(m_id);
                    m_act = 0;
                    m_drop = 0;
                    nfree = 0;
                    lowest = 0;
                    for (int i = 63; i >= 1; i--)
                        if (mfree[i]) begin nfree++; lowest = i; end
                    if (nfree > 0) begin
                        m_id = lowest;
                        mfree[m_id] = 0;
                        m_act = 1;
                        m_over = 0;
                        m_words = 1;
                        e_ram_wr = 1;
                        e_addr = 13'(m_id * 128);
                        e_data = data;
                        e_id = 8'(m_id);
                    end else begin
                        m_drop = 1;
`ifdef CACHE_DROP_CNT_EN
                        if (e_drops != 16'hFFFF) e_drops++;
`endif
                    end
                end else if (m_act) begin
                    if (m_words < 128) begin
                        e_ram_wr = 1;
                        e_addr = 13'(m_id * 128 + m_words);
                        e_data = data;
                        m_words++;
                    end else begin
                        m_over = 1;
                    end
                    if (typ == 2) begin
                        m_act = 0;
                        if (valid_wr && valid && !m_over) begin
                            e_cwr = 1;
                            e_cid = 6'(m_id);
                            e_clen = 8'(m_words);
                        end else begin
                            frees.push_back(m_id);
                        end
                    end
                end else if (m_drop && typ == 2) begin
                    m_drop = 0;
                end
            end
            foreach (frees[k]) mfree[frees[k]] = 1;
            nfree = 0;
            for (int i = 1; i < 64; i++) if (mfree[i]) nfree++;
            e_cnt = 6'(nfree);
        end
    end

    logic [12:0] ram_log[$];
    logic [13:0] com_log[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ram_wr", ram_wr, e_ram_wr);
            if (e_ram_wr) begin
                chk("ram_addr", ram_addr, e_addr);
                chk("ram_data", ram_data, e_data);
            end
            chk("commit_wr", commit_wr, e_cwr);
            if (e_cwr) begin
                chk("commit_id", commit_id, e_cid);
                chk("commit_len", commit_len, e_clen);
            end
            chk("cache_id", cache_id, e_id);
            chk("id_count", id_count, e_cnt);
            chk("cache_err", cache_err, e_err);
            chk("drop_count", drop_count, e_drops);
            if (ram_wr) ram_log.push_back(ram_addr);
            if (commit_wr) com_log.push_back({commit_id, commit_len});
        end
    end

    logic [31:0] seq = 0;

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_wr = 0; valid_wr = 0; valid = 0; rel_wr = 0;
        end
    endtask

    task automatic word(input logic [1:0] t, input logic vwr, input logic v);
        @(negedge clk);
        seq++;
        data = {t, 100'h0, seq};
        data_wr = 1; valid_wr = vwr; valid = v; rel_wr = 0;
    endtask

    task automatic pkt(input int n, input logic g);
        word(2'b01, 0, 0);
        for (int i = 1; i < n - 1; i++) word(2'b11, 0, 0);
        word(2'b10, 1, g);
    endtask

    task automatic release_id(input logic [5:0] id);
        @(negedge clk);
        data_wr = 0; valid_wr = 0; valid = 0;
        rel_id = id; rel_wr = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 0;
        data_wr = 0; valid_wr = 0; valid = 0; rel_wr = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
    endtask

    task automatic clear_logs();
        ram_log.delete();
        com_log.delete();
    endtask

    localparam logic [15:0] ONE_DROP =
`ifdef CACHE_DROP_CNT_EN
        16'd1;
`else
        16'd0;
`endif

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1;
        idle(1);
        chk("rst_count", id_count, 6'd63);
        chk("rst_id", cache_id, 8'd0);
        chk("rst_err", cache_err, 1'b0);
        chk("rst_ram_wr", ram_wr, 1'b0);
        chk("rst_commit", commit_wr, 1'b0);
        chk("rst_drop", drop_count, 16'd0);

        clear_logs();
        pkt(4, 1);
        idle(2);
        chk("s1_nwr", ram_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < ram_log.size()) chk("s1_addr", ram_log[i], 13'h080 + 13'(i));
        chk("s1_ncommit", com_log.size(), 1);
        if (com_log.size() > 0) chk("s1_commit", com_log[0], {6'd1, 8'd4});
        chk("s1_count", id_count, 6'd62);
        chk("s1_id", cache_id, 8'd1);

        clear_logs();
        pkt(2, 0);
        idle(2);
        chk("s2_bad_id", cache_id, 8'd2);
        chk("s2_bad_ncommit", com_log.size(), 0);
        chk("s2_bad_count", id_count, 6'd62);
        pkt(3, 1);
        idle(2);
        chk("s2_reuse_id", cache_id, 8'd2);
        if (com_log.size() > 0) chk("s2_commit", com_log[0], {6'd2, 8'd3});
        chk("s2_count", id_count, 6'd61);

        clear_logs();
        word(2'b01, 0, 0);
        word(2'b11, 0, 0);
        word(2'b01, 0, 0);
        word(2'b11, 0, 0);
        word(2'b10, 1, 1);
        idle(2);
        chk("rehead_id", cache_id, 8'd4);
        chk("rehead_ncommit", com_log.size(), 1);
        if (com_log.size() > 0) chk("rehead_commit", com_log[0], {6'd4, 8'd3});
        chk("rehead_count", id_count, 6'd60);
        release_id(6'd0);
        idle(2);
        chk("rel0_err", cache_err, 1'b1);
        chk("rel0_count", id_count, 6'd60);

        do_reset();
        for (int i = 0; i < 63; i++) pkt(2, 1);
        idle(2);
        chk("full_count", id_count, 6'd0);
        chk("full_id", cache_id, 8'd63);
        clear_logs();
        pkt(3, 1);
        idle(2);
        chk("drop_nwr", ram_log.size(), 0);
        chk("drop_ncommit", com_log.size(), 0);
        chk("drop_cnt1", drop_count, ONE_DROP);
        word(2'b01, 0, 0);
        rel_id = 6'd5; rel_wr = 1;
        word(2'b10, 1, 1);
        idle(1);
        pkt(2, 1);
        idle(2);
        chk("rel5_id", cache_id, 8'd5);
        chk("rel5_count", id_count, 6'd0);
        chk("drop_cnt2", drop_count, ONE_DROP * 2);
        if (com_log.size() > 0) chk("rel5_commit", com_log[0], {6'd5, 8'd2});

        do_reset();
        clear_logs();
        pkt(128, 1);
        idle(2);
        chk("max_nwr", ram_log.size(), 128);
        chk("max_ncommit", com_log.size(), 1);
        if (com_log.size() > 0) chk("max_commit", com_log[0], {6'd1, 8'd128});
        clear_logs();
        pkt(130, 1);
        idle(2);
        chk("ovr_nwr", ram_log.size(), 128);
        if (ram_log.size() > 0) chk("ovr_last", ram_log[ram_log.size()-1], 13'h17F);
        chk("ovr_ncommit", com_log.size(), 0);
        chk("ovr_count", id_count, 6'd62);

        do_reset();
        for (int i = 0; i < 3; i++) pkt(2, 1);
        idle(1);
        release_id(6'd9);
        idle(2);
        chk("relfree_err", cache_err, 1'b1);
        chk("relfree_count", id_count, 6'd60);
        word(2'b01, 0, 0);
        rel_id = 6'd3; rel_wr = 1;
        word(2'b10, 1, 1);
        idle(2);
        chk("same_id", cache_id, 8'd4);
        chk("same_count", id_count, 6'd60);

        do_reset();
        clear_logs();
        word(2'b01, 0, 0);
        word(2'b11, 0, 0);
        word(2'b11, 0, 0);
        do_reset();
        idle(2);
        chk("mid_count", id_count, 6'd63);
        chk("mid_ncommit", com_log.size(), 0);
        pkt(2, 1);
        idle(2);
        chk("mid_next_id", cache_id, 8'd1);
        if (com_log.size() > 0) chk("mid_commit", com_log[0], {6'd1, 8'd2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
